// File: rtl/cf_roi_extract.sv
// cf_roi_extract: passive tap on a multi-pixel-per-clock AXI4-Stream video bus.
// Tracks the raster position of accepted beats, captures a FFT_LENGTH x FFT_LENGTH
// window whose origin is latched at start of frame, and replays it through a small
// FIFO as an AXI4-Stream patch (tuser = first beat, tlast = end of each patch row).
// Optional feature: define CF_ROI_FRAME_CNT_EN to add the frame_cnt output, which
// presents the frame number of the patch at the FIFO head.
module cf_roi_extract #(
  parameter int NPPC           = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int POSITION_WIDTH = 12,
  parameter int FFT_LENGTH     = 64,
  parameter int HEIGHT         = 2160,
  parameter int FIFO_DEPTH     = 64
) (
  input  logic                         s_axis_video_aclk,
  input  logic                         s_axis_video_areset,
  input  logic [NPPC*DATA_WIDTH-1:0]   VIDEO_IN_tdata,
  input  logic                         VIDEO_IN_tvalid,
  input  logic                         VIDEO_IN_tready,
  input  logic                         VIDEO_IN_tuser,
  input  logic                         VIDEO_IN_tlast,
  input  logic [POSITION_WIDTH-1:0]    xStart,
  input  logic [POSITION_WIDTH-1:0]    yStart,
  output logic [NPPC*DATA_WIDTH-1:0]   PATCH_OUT_tdata,
  output logic                         PATCH_OUT_tvalid,
  input  logic                         PATCH_OUT_tready,
  output logic                         PATCH_OUT_tuser,
  output logic                         PATCH_OUT_tlast,
  output logic                         patch_done,
  output logic                         overflow
`ifdef CF_ROI_FRAME_CNT_EN
  ,
  output logic [15:0]                  frame_cnt
`endif
);

  localparam int PW  = POSITION_WIDTH;
  localparam int DW  = NPPC * DATA_WIDTH;
  localparam int BPR = FFT_LENGTH / NPPC;      // beats per patch row
  localparam int XSH = $clog2(NPPC);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DW + 3;                 // {data, first, rowlast, final}

  logic          clk, rst;
  assign clk = s_axis_video_aclk;
  assign rst = s_axis_video_areset;

  logic          beat, sof;
  logic [PW-1:0] x_pos, y_pos, xs_q, ys_q;
  logic          armed_q;
  logic [PW-1:0] cur_x, cur_y, cur_xs, cur_ys;
  logic [PW:0]   x_ext, y_ext, xs_ext, ys_ext, xs_end, ys_end;
  logic          in_win, first, rowlast, final_beat;

  assign beat = VIDEO_IN_tvalid & VIDEO_IN_tready;
  assign sof  = beat & VIDEO_IN_tuser;

  // Position and window origin of the beat on the bus; a start-of-frame beat is (0,0) with fresh origin
  always_comb begin
    cur_x      = sof ? '0 : x_pos;
    cur_y      = sof ? '0 : y_pos;
    cur_xs     = sof ? (xStart >> XSH) : xs_q;
    cur_ys     = sof ? yStart : ys_q;
    x_ext      = {1'b0, cur_x};
    y_ext      = {1'b0, cur_y};
    xs_ext     = {1'b0, cur_xs};
    ys_ext     = {1'b0, cur_ys};
    xs_end     = xs_ext + (PW+1)'(BPR);
    ys_end     = ys_ext + (PW+1)'(FFT_LENGTH);
    in_win     = beat & (armed_q | sof) &
                 (y_ext >= ys_ext) & (y_ext < ys_end) &
                 (x_ext >= xs_ext) & (x_ext < xs_end);
    first      = (cur_y == cur_ys) & (cur_x == cur_xs);
    rowlast    = (x_ext == xs_end - (PW+1)'(1)) | VIDEO_IN_tlast;
    final_beat = rowlast & (y_ext == ys_end - (PW+1)'(1));
  end

  // Raster counters and arming; start of frame overrides the running count
  always_ff @(posedge clk) begin
    if (rst) begin
      x_pos   <= '0;
      y_pos   <= '0;
      armed_q <= 1'b0;
    end else if (beat) begin
      if (sof) armed_q <= 1'b1;
      if (VIDEO_IN_tlast) begin
        x_pos <= '0;
        y_pos <= (cur_y == PW'(HEIGHT-1)) ? '0 : cur_y + PW'(1);
      end else begin
        x_pos <= cur_x + PW'(1);
        y_pos <= cur_y;
      end
    end
  end

  // Window origin is frozen for the frame once latched on the start-of-frame beat
  always_ff @(posedge clk) begin
    if (sof) begin
      xs_q <= cur_xs;
      ys_q <= cur_ys;
    end
  end

  logic [AW:0]   wr_ptr, rd_ptr, fill;
  logic          empty, full, pop, push, drop;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;

  // A pop in the same cycle frees a slot, so a window beat arriving while full is still accepted
  always_comb begin
    fill  = wr_ptr - rd_ptr;
    empty = (wr_ptr == rd_ptr);
    full  = (fill == (AW+1)'(FIFO_DEPTH));
    pop   = ~empty & PATCH_OUT_tready;
    push  = in_win & (~full | pop);
    drop  = in_win & full & ~pop;
    head  = mem[rd_ptr[AW-1:0]];
  end

  // Patch storage; contents are qualified by the pointers, so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {VIDEO_IN_tdata, first, rowlast, final_beat};
  end

  // FIFO pointers, completion pulse and sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      patch_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      patch_done <= pop & head[0];
      if (sof)       overflow <= drop;
      else if (drop) overflow <= 1'b1;
    end
  end

  assign PATCH_OUT_tvalid = ~empty;
  assign PATCH_OUT_tdata  = head[EW-1:3];
  assign PATCH_OUT_tuser  = ~empty & head[2];
  assign PATCH_OUT_tlast  = ~empty & head[1];

`ifdef CF_ROI_FRAME_CNT_EN
  logic [15:0] fc_q, cur_fc;
  logic [15:0] fc_mem [FIFO_DEPTH];

  assign cur_fc = sof ? fc_q + 16'd1 : fc_q;

  // Frame counter advances on every start-of-frame beat and wraps naturally
  always_ff @(posedge clk) begin
    if (rst)      fc_q <= '0;
    else if (sof) fc_q <= cur_fc;
  end

  // Frame number travels with each stored beat so the head shows its own frame
  always_ff @(posedge clk) begin
    if (push) fc_mem[wr_ptr[AW-1:0]] <= cur_fc;
  end

  assign frame_cnt = fc_mem[rd_ptr[AW-1:0]];
`endif

endmodule
